apb_spi_ctrl: RTL and testbench
===============================

Name: apb_spi_ctrl

Overview:
APB3 slave that configures and sequences the 16-bit SPI master core (send/data_in/data_out/done handshake). Software writes words into a TX FIFO; the controller issues one SPI transfer per word, captures each received word into an RX holding register, and raises an interrupt. It sits between the APB bus and the SPI core in the APB-SPI bridge top level.

Parameters:
TX_DEPTH, 4, TX FIFO depth in 16-bit words (power of 2, >=2)
TIMEOUT, 1024, clk cycles to wait for spi_done before aborting a transfer

Ports:
clk  in  1  system clock (10 MHz nominal)
nrst  in  1  reset, asynchronous, active-low
PSEL  in  1  APB select
PENABLE  in  1  APB enable (access phase)
PWRITE  in  1  APB write/read
PADDR  in  4  byte address; bits [3:2] select register
PWDATA  in  32  APB write data
PRDATA  out  32  APB read data
PREADY  out  1  tied 1 (zero wait states)
PSLVERR  out  1  APB error, valid in access phase
spi_send  out  1  one-cycle start pulse to SPI core
spi_data_in  out  16  TX word to SPI core
spi_data_out  in  16  RX word from SPI core, valid when spi_done=1
spi_done  in  1  one-cycle completion pulse from SPI core
irq  out  1  level interrupt

Behaviour:
- Single clock domain; clk and nrst as named; reset asynchronous, active-low.
- Reset values: PRDATA=0, PSLVERR=0, spi_send=0, spi_data_in=0, irq=0; FIFO empty, all registers 0, FSM IDLE, timeout counter 0.
- APB write commits when PSEL&PENABLE&PWRITE; read data driven combinationally from address during access phase (PRDATA=0 when not selected).
- Register map (PADDR[3:2]):
  - 0x0 CTRL RW: [0] EN, [1] IE. Others read 0.
  - 0x4 STATUS: [0] BUSY (FSM != IDLE), [1] TX_FULL, [2] TX_EMPTY, [3] RX_VALID, [4] OVR, [5] TMO. Write 1 clears OVR/TMO; other bits RO.
  - 0x8 TXDATA WO: PWDATA[15:0] pushed to FIFO. Reads return 0.
  - 0xC RXDATA RO: {16'b0, rx_word}; read in access phase clears RX_VALID next cycle.
- PSLVERR=1 for: write to TXDATA when FIFO full (word dropped), write to RXDATA, PADDR[1:0]!=0. Register state unchanged on error.
- FSM:
  - IDLE: if EN=1 and FIFO not empty -> LOAD.
  - LOAD: pop FIFO head into spi_data_in; -> START.
  - START: spi_send=1 for exactly this cycle; timeout counter cleared; -> WAIT.
  - WAIT: on spi_done: rx_word<=spi_data_out; if RX_VALID already 1 (and not being cleared this cycle) set OVR, rx_word still overwritten; RX_VALID<=1; -> IDLE. If counter reaches TIMEOUT-1 without spi_done: set TMO, -> IDLE, rx_word unchanged.
- spi_data_in held stable from LOAD until next LOAD (core may sample late).
- Back-to-back: min 3 clk from spi_done to next spi_send (WAIT->IDLE->LOAD->START).
- Clearing EN mid-transfer does not abort; current transfer completes, no new LOAD.
- Simultaneous push and pop on full FIFO: pop occurs in LOAD, push accepted only if not full at the write cycle (full checked before pop); simultaneous push/pop when not full keeps count.
- Simultaneous RXDATA read and spi_done: new word captured, RX_VALID stays 1, no OVR.
- Simultaneous W1C and hardware set of OVR/TMO: set wins.
- spi_done outside WAIT ignored.
- irq = IE & (RX_VALID | TMO | (TX_EMPTY & ~BUSY & EN)).
- FIFO pointers wrap modulo TX_DEPTH; count width log2(TX_DEPTH)+1.

Test Plan:
- Reset: drive nrst=0 mid-WAIT -> all outputs 0, STATUS reads 0x04 (TX_EMPTY only) after release.
- Single transfer: CTRL=0x3, TXDATA=0xAA33, core model returns 0xAAAA after 16x16 clk -> one spi_send pulse, spi_data_in=0xAA33, STATUS[3]=1, irq=1, RXDATA read=0x0000AAAA, RX_VALID cleared.
- Burst: EN=0, push 0x8888,0x1234,0x5678,0x9ABC -> TX_FULL=1; 5th push PSLVERR=1; set EN -> four transfers in order, spi_send spacing >= 3 clk after each done, OVR=1 if RXDATA not read.
- Timeout: core never asserts spi_done, TIMEOUT=1024 -> TMO=1 exactly 1024 clk after spi_send, FSM IDLE; write 0x20 to STATUS clears TMO.
- Read/done collision: RXDATA read same cycle as spi_done returning 0x0AA8 -> RX_VALID=1, OVR=0, next read returns 0x0AA8.
- Bad access: write RXDATA, PADDR=0x1 -> PSLVERR=1, no register change; EN cleared during WAIT -> transfer completes, no further spi_send.

Source files
------------

// File: rtl/apb_spi_ctrl_if.sv
// APB3 bus bundle between the host bridge and the SPI controller register block.
// Latency: none, pure wiring.
// Backpressure: none, PREADY is driven by the slave.
interface apb_spi_ctrl_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_spi_ctrl.sv
// APB3 register block that queues TX words and sequences one 16-bit SPI transfer per word.
// Latency: zero-wait-state APB; spi_send two cycles after EN & FIFO non-empty, 3 cycles min done->send.
// Backpressure: none on APB (PREADY=1); full TX FIFO rejects pushes with PSLVERR, core paced by spi_done/timeout.
module apb_spi_ctrl #(
    parameter int TX_DEPTH = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic               clk,
    input  logic               nrst,
    apb_spi_ctrl_if.slave      apb,
    output logic               spi_send,
    output logic [15:0]        spi_data_in,
    input  logic [15:0]        spi_data_out,
    input  logic               spi_done,
    output logic               irq
);

    localparam int AW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_TXDATA = 2'd2;
    localparam logic [1:0] A_RXDATA = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_START = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            en_q, en_d;
    logic            ie_q, ie_d;
    logic [15:0]     mem_q [TX_DEPTH];
    logic [15:0]     mem_d [TX_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     tx_word_q, tx_word_d;
    logic [15:0]     rx_word_q, rx_word_d;
    logic            rx_valid_q, rx_valid_d;
    logic            ovr_q, ovr_d;
    logic            tmo_q, tmo_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;

    logic            access;
    logic [1:0]      sel;
    logic            addr_ok;
    logic            tx_full;
    logic            tx_empty;
    logic            busy;
    logic            bus_err;
    logic            wr_ok;
    logic            rd_ok;
    logic            push;
    logic            pop;
    logic            rx_clr;
    logic            capture;
    logic            tmo_hit;
    logic [31:0]     prdata;
    logic            unused_pwdata;

    assign unused_pwdata = ^apb.PWDATA[31:16];

    // APB decode: errors are resolved before any state update so a rejected access changes nothing
    always_comb begin
        access   = apb.PSEL & apb.PENABLE;
        sel      = apb.PADDR[3:2];
        addr_ok  = (apb.PADDR[1:0] == 2'b00);
        tx_full  = (count_q == CW'(TX_DEPTH));
        tx_empty = (count_q == '0);
        busy     = (state_q != S_IDLE);
        bus_err  = access & (~addr_ok
                           | (apb.PWRITE & (sel == A_RXDATA))
                           | (apb.PWRITE & (sel == A_TXDATA) & tx_full));
        wr_ok    = access &  apb.PWRITE & ~bus_err;
        rd_ok    = access & ~apb.PWRITE & ~bus_err;
        push     = wr_ok & (sel == A_TXDATA);
        rx_clr   = rd_ok & (sel == A_RXDATA);
    end

    // Read mux: only a clean read access drives data, everything else returns zero
    always_comb begin
        prdata = '0;
        if (rd_ok) begin
            case (sel)
                A_CTRL:   prdata = {30'b0, ie_q, en_q};
                A_STATUS: prdata = {26'b0, tmo_q, ovr_q, rx_valid_q, tx_empty, tx_full, busy};
                A_RXDATA: prdata = {16'b0, rx_word_q};
                default:  prdata = '0;
            endcase
        end
    end

    assign apb.PRDATA  = prdata;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = bus_err;

    // Transfer sequencer: IDLE -> LOAD (pop) -> START (send pulse) -> WAIT (done or timeout)
    always_comb begin
        state_d   = state_q;
        tx_word_d = tx_word_q;
        tmo_cnt_d = tmo_cnt_q;
        pop       = 1'b0;
        capture   = 1'b0;
        tmo_hit   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en_q && !tx_empty) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                pop       = 1'b1;
                tx_word_d = mem_q[rd_ptr_q];
                state_d   = S_START;
            end
            S_START: begin
                tmo_cnt_d = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (spi_done) begin
                    capture = 1'b1;
                    state_d = S_IDLE;
                end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                    tmo_hit = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // TX FIFO: full is judged on the pre-pop count, so a push on a full FIFO is dropped even during LOAD
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = apb.PWDATA[15:0];
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Control and status: hardware set beats software clear for RX_VALID, OVR and TMO
    always_comb begin
        en_d       = en_q;
        ie_d       = ie_q;
        rx_word_d  = rx_word_q;
        rx_valid_d = rx_valid_q;
        ovr_d      = ovr_q;
        tmo_d      = tmo_q;
        if (wr_ok && (sel == A_CTRL)) begin
            en_d = apb.PWDATA[0];
            ie_d = apb.PWDATA[1];
        end
        if (wr_ok && (sel == A_STATUS)) begin
            if (apb.PWDATA[4]) ovr_d = 1'b0;
            if (apb.PWDATA[5]) tmo_d = 1'b0;
        end
        if (rx_clr) begin
            rx_valid_d = 1'b0;
        end
        if (capture) begin
            rx_word_d  = spi_data_out;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rx_clr) begin
                ovr_d = 1'b1;
            end
        end
        if (tmo_hit) begin
            tmo_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= S_IDLE;
            en_q       <= 1'b0;
            ie_q       <= 1'b0;
            for (int i = 0; i < TX_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_word_q  <= '0;
            rx_word_q  <= '0;
            rx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
            tmo_q      <= 1'b0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            ie_q       <= ie_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_word_q  <= tx_word_d;
            rx_word_q  <= rx_word_d;
            rx_valid_q <= rx_valid_d;
            ovr_q      <= ovr_d;
            tmo_q      <= tmo_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    // Core-facing outputs: the TX word is held from LOAD until the next LOAD for late sampling
    assign spi_send    = (state_q == S_START);
    assign spi_data_in = tx_word_q;
    assign irq         = ie_q & (rx_valid_q | tmo_q | (tx_empty & ~busy & en_q));

endmodule

// File: tb/tb_apb_spi_ctrl.sv
// Scoreboard bench for apb_spi_ctrl: APB responses and SPI start words are queued at issue time.
// Latency: core model answers after a programmable delay; checks sampled on the falling edge.
// Backpressure: none; every wait on the DUT is bounded by a cycle budget.
module tb_apb_spi_ctrl;

    typedef struct {
        logic        is_rd;
        logic [31:0] dat;
        logic        err;
        string       nm;
    } apb_exp_t;

    logic        clk;
    logic        nrst;
    logic        spi_send;
    logic [15:0] spi_data_in;
    logic [15:0] spi_data_out;
    logic        spi_done;
    logic        irq;

    logic        model_done;
    logic [15:0] model_dat;
    logic        man_done;
    logic [15:0] man_dat;
    logic        core_auto;
    int          resp_dly;

    apb_exp_t    apb_q[$];
    logic [15:0] spi_q[$];
    logic [15:0] resp_q[$];

    int          n_cmp;
    int          n_bad;
    int          cyc;
    int          done_cnt;
    int          last_done;
    logic        have_done;
    logic        prev_send;
    apb_exp_t    mon_e;
    logic [15:0] mon_w;

    apb_spi_ctrl_if bus ();

    assign spi_done     = model_done | man_done;
    assign spi_data_out = man_done ? man_dat : model_dat;

    apb_spi_ctrl #(.TX_DEPTH(4), .TIMEOUT(1024)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .apb          (bus.slave),
        .spi_send     (spi_send),
        .spi_data_in  (spi_data_in),
        .spi_data_out (spi_data_out),
        .spi_done     (spi_done),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: APB responses, SPI start words, pulse width and done->send spacing
    always @(negedge clk) begin
        if (nrst && bus.PSEL && bus.PENABLE) begin
            n_cmp++;
            if (apb_q.size() == 0) begin
                n_bad++;
                $display("FAIL apb_unexpected: access to %h with nothing queued", bus.PADDR);
            end else begin
                mon_e = apb_q.pop_front();
                if (bus.PSLVERR !== mon_e.err) begin
                    n_bad++;
                    $display("FAIL %s pslverr: got %b, required %b", mon_e.nm, bus.PSLVERR, mon_e.err);
                end
                if (mon_e.is_rd) begin
                    n_cmp++;
                    if (bus.PRDATA !== mon_e.dat) begin
                        n_bad++;
                        $display("FAIL %s prdata: got %h, required %h", mon_e.nm, bus.PRDATA, mon_e.dat);
                    end
                end
            end
        end
        if (nrst && spi_send) begin
            n_cmp++;
            if (spi_q.size() == 0) begin
                n_bad++;
                $display("FAIL spi_unexpected: send with word %h, none expected", spi_data_in);
            end else begin
                mon_w = spi_q.pop_front();
                if (spi_data_in !== mon_w) begin
                    n_bad++;
                    $display("FAIL spi_word: got %h, required %h", spi_data_in, mon_w);
                end
            end
            n_cmp++;
            if (prev_send) begin
                n_bad++;
                $display("FAIL send_width: got 2+ cycle pulse, required 1");
            end
            if (have_done) begin
                n_cmp++;
                if (cyc - last_done < 3) begin
                    n_bad++;
                    $display("FAIL send_spacing: got %0d cycles after done, required >= 3", cyc - last_done);
                end
            end
        end
        if (nrst && spi_done) begin
            done_cnt++;
            last_done = cyc;
            have_done = 1'b1;
        end
        prev_send = spi_send;
    end

    // SPI core model: answers each send with the next queued RX word after resp_dly cycles
    initial begin
        logic [15:0] r;
        model_done = 1'b0;
        model_dat  = '0;
        forever begin
            @(negedge clk);
            if (nrst && spi_send && core_auto && resp_q.size() > 0) begin
                r = resp_q.pop_front();
                repeat (resp_dly) @(posedge clk);
                #1 model_done = 1'b1; model_dat = r;
                @(posedge clk);
                #1 model_done = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic apb(input logic wr, input logic [3:0] a, input logic [31:0] wd,
                       input logic [31:0] ed, input logic ee,
                       input logic dpulse, input logic [15:0] ddat, input string nm);
        apb_exp_t e;
        e.is_rd = !wr;
        e.dat   = ed;
        e.err   = ee;
        e.nm    = nm;
        @(posedge clk);
        #1 bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = a; bus.PWDATA = wd;
        apb_q.push_back(e);
        @(posedge clk);
        #1 bus.PENABLE = 1'b1;
        if (dpulse) begin
            man_done = 1'b1;
            man_dat  = ddat;
        end
        @(posedge clk);
        #1 bus.PSEL = 1'b0; bus.PENABLE = 1'b0; man_done = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic ee, input string nm);
        apb(1'b1, a, d, 32'h0, ee, 1'b0, 16'h0, nm);
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] ed, input logic ee, input string nm);
        apb(1'b0, a, 32'h0, ed, ee, 1'b0, 16'h0, nm);
    endtask

    task automatic wait_dones(input int n, input int budget, input string nm);
        int tgt;
        int t;
        tgt = done_cnt + n;
        t   = 0;
        while (done_cnt < tgt && t < budget) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        n_cmp++;
        if (done_cnt < tgt) begin
            n_bad++;
            $display("FAIL %s: got %0d done pulses, required %0d", nm, n - (tgt - done_cnt), n);
        end
    endtask

    task automatic wait_send(input int budget, input string nm, output int at);
        int t;
        t  = 0;
        at = -1;
        while (t < budget) begin
            @(negedge clk);
            if (spi_send) begin
                at = cyc;
                break;
            end
            t++;
        end
        n_cmp++;
        if (at < 0) begin
            n_bad++;
            $display("FAIL %s: got no spi_send within %0d cycles, required one", nm, budget);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        n_cmp = 0; n_bad = 0; cyc = 0; done_cnt = 0; last_done = 0;
        have_done = 1'b0; prev_send = 1'b0;
        man_done = 1'b0; man_dat = '0; core_auto = 1'b0; resp_dly = 20;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
        nrst = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_send", {31'b0, spi_send}, 32'h0);
        chk("rst_data_in", {16'b0, spi_data_in}, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_pslverr", {31'b0, bus.PSLVERR}, 32'h0);
        nrst = 1'b1;
        rd(4'h4, 32'h04, 1'b0, "rst_status");
        rd(4'h0, 32'h00, 1'b0, "rst_ctrl");

        // Single transfer, core answers after 16x16 clocks
        core_auto = 1'b1; resp_dly = 256;
        spi_q.push_back(16'hAA33); resp_q.push_back(16'hAAAA);
        wr(4'h8, 32'h0000AA33, 1'b0, "single_push");
        wr(4'h0, 32'h3, 1'b0, "single_ctrl");
        wait_send(20, "single_send", s);
        chk("single_irq_busy", {31'b0, irq}, 32'h0);
        wait_dones(1, 400, "single_done");
        chk("single_irq_rx", {31'b0, irq}, 32'h1);
        chk("single_hold", {16'b0, spi_data_in}, 32'hAA33);
        rd(4'h4, 32'h0C, 1'b0, "single_status");
        rd(4'hC, 32'h0000AAAA, 1'b0, "single_rxdata");
        rd(4'h4, 32'h04, 1'b0, "single_status_clr");

        // Burst: fill with EN=0, overflow push, then drain in order
        resp_dly = 20;
        wr(4'h0, 32'h2, 1'b0, "burst_ctrl_off");
        wr(4'h8, 32'h8888, 1'b0, "burst_push0");
        wr(4'h8, 32'h1234, 1'b0, "burst_push1");
        wr(4'h8, 32'h5678, 1'b0, "burst_push2");
        wr(4'h8, 32'h9ABC, 1'b0, "burst_push3");
        rd(4'h4, 32'h02, 1'b0, "burst_full");
        wr(4'h8, 32'hDEAD, 1'b1, "burst_push_full");
        spi_q.push_back(16'h8888); spi_q.push_back(16'h1234);
        spi_q.push_back(16'h5678); spi_q.push_back(16'h9ABC);
        resp_q.push_back(16'h1001); resp_q.push_back(16'h1002);
        resp_q.push_back(16'h1003); resp_q.push_back(16'h1004);
        wr(4'h0, 32'h3, 1'b0, "burst_ctrl_on");
        wait_dones(4, 400, "burst_done");
        rd(4'h4, 32'h1C, 1'b0, "burst_ovr");
        rd(4'hC, 32'h1004, 1'b0, "burst_rxdata");
        wr(4'h4, 32'h10, 1'b0, "burst_w1c");
        rd(4'h4, 32'h04, 1'b0, "burst_status_clr");

        // Timeout: abort decision 1024 cycles after the send cycle, flag visible the cycle after
        core_auto = 1'b0;
        spi_q.push_back(16'h5A5A);
        wr(4'h8, 32'h5A5A, 1'b0, "tmo_push");
        wait_send(20, "tmo_send", s);
        wr(4'h0, 32'h2, 1'b0, "tmo_ctrl_ie");
        while (cyc < s + 1024) @(negedge clk);
        chk("tmo_irq_before", {31'b0, irq}, 32'h0);
        @(negedge clk);
        chk("tmo_irq_after", {31'b0, irq}, 32'h1);
        rd(4'h4, 32'h24, 1'b0, "tmo_status");
        wr(4'h4, 32'h20, 1'b0, "tmo_w1c");
        rd(4'h4, 32'h04, 1'b0, "tmo_status_clr");

        // RXDATA read colliding with spi_done
        wr(4'h0, 32'h3, 1'b0, "col_ctrl");
        core_auto = 1'b1; resp_dly = 10;
        spi_q.push_back(16'h0101); resp_q.push_back(16'h1111);
        wr(4'h8, 32'h0101, 1'b0, "col_push0");
        wait_dones(1, 100, "col_done0");
        core_auto = 1'b0;
        spi_q.push_back(16'h0202);
        wr(4'h8, 32'h0202, 1'b0, "col_push1");
        wait_send(20, "col_send", s);
        apb(1'b0, 4'hC, 32'h0, 32'h1111, 1'b0, 1'b1, 16'h0AA8, "col_read");
        rd(4'h4, 32'h0C, 1'b0, "col_status");
        rd(4'hC, 32'h0AA8, 1'b0, "col_rxdata");
        rd(4'h4, 32'h04, 1'b0, "col_status_clr");

        // Bad accesses leave state untouched
        wr(4'hC, 32'h1234, 1'b1, "bad_wr_rx");
        wr(4'h1, 32'h0, 1'b1, "bad_wr_misalign");
        rd(4'h5, 32'h0, 1'b1, "bad_rd_misalign");
        rd(4'h0, 32'h3, 1'b0, "bad_ctrl_kept");
        rd(4'h8, 32'h0, 1'b0, "bad_rd_tx");
        rd(4'h4, 32'h04, 1'b0, "bad_status_kept");

        // EN cleared mid-transfer: current word completes, the next stays queued
        wr(4'h0, 32'h2, 1'b0, "en_off");
        spi_q.push_back(16'h3333);
        wr(4'h8, 32'h3333, 1'b0, "en_push0");
        wr(4'h8, 32'h4444, 1'b0, "en_push1");
        core_auto = 1'b1; resp_dly = 30; resp_q.push_back(16'h7777);
        wr(4'h0, 32'h3, 1'b0, "en_on");
        wait_send(20, "en_send", s);
        wr(4'h0, 32'h2, 1'b0, "en_clear_wait");
        wait_dones(1, 100, "en_done");
        repeat (40) @(negedge clk);
        rd(4'h4, 32'h08, 1'b0, "en_status");
        rd(4'hC, 32'h7777, 1'b0, "en_rxdata");
        @(posedge clk);
        #1 man_done = 1'b1; man_dat = 16'hFFFF;
        @(posedge clk);
        #1 man_done = 1'b0;
        rd(4'h4, 32'h00, 1'b0, "idle_done_status");
        rd(4'hC, 32'h7777, 1'b0, "idle_done_rxdata");

        // Reset asserted while waiting for the core
        core_auto = 1'b0;
        spi_q.push_back(16'h4444);
        wr(4'h0, 32'h3, 1'b0, "rstw_ctrl");
        wait_send(20, "rstw_send", s);
        repeat (5) @(negedge clk);
        chk("rstw_irq_busy", {31'b0, irq}, 32'h0);
        nrst = 1'b0;
        #1;
        chk("rstw_send", {31'b0, spi_send}, 32'h0);
        chk("rstw_data_in", {16'b0, spi_data_in}, 32'h0);
        chk("rstw_irq", {31'b0, irq}, 32'h0);
        chk("rstw_prdata", bus.PRDATA, 32'h0);
        @(negedge clk);
        nrst = 1'b1;
        rd(4'h4, 32'h04, 1'b0, "rstw_status");
        rd(4'h0, 32'h00, 1'b0, "rstw_ctrl_after");

        repeat (4) @(negedge clk);
        chk("apb_queue_drained", apb_q.size(), 32'h0);
        chk("spi_queue_drained", spi_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
